// File: rtl/uart_core.sv
// uart_core: 8N1 UART, independent transmitter and receiver on one clock.
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   tx_start  in   one-cycle request to send tx_data (accepted only when idle)
//   tx_data   in   byte to transmit, latched on an accepted tx_start
//   rx        in   serial input, idle high, asynchronous to clk
//   tx        out  serial output, idle high
//   tx_busy   out  high while a TX frame is in progress
//   tx_done   out  one-cycle pulse at the end of the TX stop bit
//   rx_data   out  last correctly received byte
//   rx_busy   out  high from start-bit detection until the frame ends
//   rx_done   out  one-cycle pulse, rx_data valid in the same cycle
module uart_core #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 9600,
    parameter int unsigned OVERSAMP = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       rx,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done,
    output logic [7:0] rx_data,
    output logic       rx_busy,
    output logic       rx_done
);

    localparam int unsigned TICK_DIV     = CLK_FREQ / (BAUD * OVERSAMP);
    localparam int unsigned DIV_W        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    // Sub-tick counter must reach 1.5 bits in the RX stop state.
    localparam int unsigned SUB_W        = $clog2(OVERSAMP + OVERSAMP / 2);
    localparam int unsigned SUB_LAST     = OVERSAMP - 1;
    localparam int unsigned SUB_MID      = OVERSAMP / 2 - 1;
    localparam int unsigned SUB_STOP_END = OVERSAMP + OVERSAMP / 2 - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    state_t             tx_state;
    logic [DIV_W-1:0]   tx_div;
    logic [SUB_W-1:0]   tx_sub;
    logic [2:0]         tx_bit;
    logic [7:0]         tx_shift;
    logic               tx_tick;
    logic               tx_bit_end;

    assign tx_tick    = (tx_div == DIV_W'(TICK_DIV - 1));
    assign tx_bit_end = tx_tick && (tx_sub == SUB_W'(SUB_LAST));

    // TX frame sequencer: each bit held for OVERSAMP sub-ticks
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= ST_IDLE;
            tx_div   <= '0;
            tx_sub   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (tx_state != ST_IDLE) begin
                tx_div <= tx_tick ? '0 : tx_div + DIV_W'(1);
                if (tx_tick) begin
                    tx_sub <= tx_bit_end ? '0 : tx_sub + SUB_W'(1);
                end
            end
            case (tx_state)
                ST_IDLE: begin
                    if (tx_start) begin
                        tx_shift <= tx_data;
                        tx_busy  <= 1'b1;
                        tx       <= 1'b0;
                        tx_div   <= '0;
                        tx_sub   <= '0;
                        tx_bit   <= '0;
                        tx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (tx_bit_end) begin
                        tx       <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tx_bit_end) begin
                        if (tx_bit == 3'd7) begin
                            tx       <= 1'b1;
                            tx_state <= ST_STOP;
                        end else begin
                            tx       <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx_bit   <= tx_bit + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tx_bit_end) begin
                        tx_done  <= 1'b1;
                        tx_busy  <= 1'b0;
                        tx_state <= ST_IDLE;
                    end
                end
                default: tx_state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    state_t             rx_state;
    logic [1:0]         rx_sync;
    logic               rx_prev;
    logic               rx_s;
    logic [DIV_W-1:0]   rx_div;
    logic [SUB_W-1:0]   rx_sub;
    logic [2:0]         rx_bit;
    logic [7:0]         rx_shift;
    logic               rx_stop;
    logic               rx_tick;

    assign rx_s    = rx_sync[1];
    assign rx_tick = (rx_div == DIV_W'(TICK_DIV - 1));

    // RX frame sequencer: samples mid-bit, finishes at the end of the stop bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state <= ST_IDLE;
            rx_sync  <= 2'b11;
            rx_prev  <= 1'b1;
            rx_div   <= '0;
            rx_sub   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_stop  <= 1'b0;
            rx_data  <= '0;
            rx_busy  <= 1'b0;
            rx_done  <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            rx_sync <= {rx_sync[0], rx};
            rx_prev <= rx_s;
            if (rx_state != ST_IDLE) begin
                rx_div <= rx_tick ? '0 : rx_div + DIV_W'(1);
                if (rx_tick) begin
                    rx_sub <= rx_sub + SUB_W'(1);
                end
            end
            case (rx_state)
                ST_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        rx_div   <= '0;
                        rx_sub   <= '0;
                        rx_busy  <= 1'b1;
                        rx_state <= ST_START;
                    end
                end
                ST_START: begin
                    // Half a bit in: a high line means the edge was a glitch
                    if (rx_tick && rx_sub == SUB_W'(SUB_MID)) begin
                        rx_sub <= '0;
                        rx_bit <= '0;
                        if (rx_s) begin
                            rx_busy  <= 1'b0;
                            rx_state <= ST_IDLE;
                        end else begin
                            rx_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_tick && rx_sub == SUB_W'(SUB_LAST)) begin
                        rx_sub   <= '0;
                        rx_shift <= {rx_s, rx_shift[7:1]};
                        if (rx_bit == 3'd7) begin
                            rx_state <= ST_STOP;
                        end else begin
                            rx_bit <= rx_bit + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    // Sample mid stop bit, then run on to the end of the bit
                    if (rx_tick && rx_sub == SUB_W'(SUB_LAST)) begin
                        rx_stop <= rx_s;
                    end
                    if (rx_tick && rx_sub == SUB_W'(SUB_STOP_END)) begin
                        if (rx_stop) begin
                            rx_data <= rx_shift;
                            rx_done <= 1'b1;
                        end
                        rx_sub   <= '0;
                        rx_busy  <= 1'b0;
                        rx_state <= ST_IDLE;
                    end
                end
                default: rx_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed bench for uart_core with a byte scoreboard.
// The DUT runs with a scaled clock ratio (4 clk per sub-tick, 64 clk per bit).
`timescale 1ns/1ps
module tb_uart_core;

    localparam int unsigned CLK_FREQ = 614_400;
    localparam int unsigned BAUD     = 9600;
    localparam int unsigned OVERSAMP = 16;
    localparam int unsigned TICK_DIV = CLK_FREQ / (BAUD * OVERSAMP);
    localparam int          BIT_CLK  = int'(OVERSAMP * TICK_DIV);
    localparam int          CLK_NS   = 10;
    localparam int          BIT_NS   = BIT_CLK * CLK_NS;

    logic       clk;
    logic       reset;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       rx;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;
    logic [7:0] rx_data;
    logic       rx_busy;
    logic       rx_done;

    logic       loop_en;
    logic       man_start;
    logic [7:0] man_data;

    // Top-level loopback wiring when loop_en is set
    assign tx_start = man_start | (loop_en & rx_done);
    assign tx_data  = loop_en ? rx_data : man_data;

    uart_core #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .OVERSAMP (OVERSAMP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .rx       (rx),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .rx_data  (rx_data),
        .rx_busy  (rx_busy),
        .rx_done  (rx_done)
    );

    initial clk = 1'b0;
    always #(CLK_NS / 2) clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] rx_exp[$];
    logic [7:0] tx_exp[$];
    logic [7:0] last_rx;

    // Event counters sampled away from the active edge
    int rx_done_cnt = 0;
    int tx_done_cnt = 0;
    int busy_cnt    = 0;
    always @(negedge clk) begin
        if (rx_done === 1'b1) rx_done_cnt <= rx_done_cnt + 1;
        if (tx_done === 1'b1) tx_done_cnt <= tx_done_cnt + 1;
        if (tx_busy === 1'b1) busy_cnt    <= busy_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_lvl);
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(BIT_NS);
        end
        rx = stop_lvl;
        #(BIT_NS);
        rx = 1'b1;
    endtask

    task automatic wait_rx_done(input int budget, output logic got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (rx_done === 1'b1) got = 1'b1;
        end
    endtask

    // Pops the scoreboard and checks rx_data in the rx_done cycle
    task automatic compare_rx(input string tag, input logic got);
        logic [7:0] e;
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_sb_depth"}, 32'(rx_exp.size()), 32'd1);
        e = (rx_exp.size() > 0) ? rx_exp.pop_front() : 8'h00;
        check({tag, "_data"}, 32'(rx_data), 32'(e));
        if (got) last_rx = e;
    endtask

    task automatic decode_tx(input int budget, output logic [7:0] d, output logic stopb, output int lat);
        lat   = 0;
        d     = 8'h00;
        stopb = 1'b0;
        while (tx !== 1'b0 && lat < budget) begin
            @(negedge clk);
            lat++;
        end
        if (lat < budget) begin
            repeat (BIT_CLK + BIT_CLK / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                d[i] = tx;
                repeat (BIT_CLK) @(negedge clk);
            end
            stopb = tx;
        end
    endtask

    task automatic compare_tx(input string tag, input logic [7:0] d, input logic stopb);
        logic [7:0] e;
        check({tag, "_sb_depth"}, 32'(tx_exp.size()), 32'd1);
        e = (tx_exp.size() > 0) ? tx_exp.pop_front() : 8'h00;
        check({tag, "_data"}, 32'(d), 32'(e));
        check({tag, "_stop"}, 32'(stopb), 32'd1);
    endtask

    initial begin
        #(300_000 * CLK_NS / 10);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       got;
        logic [7:0] d;
        logic       stopb;
        int         lat;
        int         rx0, tx0, b0;
        logic       tx_low_seen;

        reset     = 1'b0;
        rx        = 1'b1;
        loop_en   = 1'b0;
        man_start = 1'b0;
        man_data  = 8'h00;
        last_rx   = 8'h00;

        // 1. Reset values, then idle line after release
        repeat (5) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_tx_busy", 32'(tx_busy), 32'd0);
        check("rst_tx_done", 32'(tx_done), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_rx_busy", 32'(rx_busy), 32'd0);
        check("rst_rx_done", 32'(rx_done), 32'd0);
        reset = 1'b1;
        tx_low_seen = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1) tx_low_seen = 1'b1;
        end
        check("idle_tx_high", 32'(tx_low_seen), 32'd0);
        check("idle_rx_pulses", 32'(rx_done_cnt), 32'd0);
        check("idle_tx_pulses", 32'(tx_done_cnt), 32'd0);

        // 2. Receive 8'h30
        rx0 = rx_done_cnt;
        rx_exp.push_back(8'h30);
        #3;
        send_rx(8'h30, 1'b1);
        wait_rx_done(2 * BIT_CLK, got);
        compare_rx("rx30", got);
        @(negedge clk);
        check("rx30_busy_low", 32'(rx_busy), 32'd0);
        repeat (BIT_CLK) @(negedge clk);
        check("rx30_one_pulse", 32'(rx_done_cnt - rx0), 32'd1);

        // 3. Loopback echo of 8'h30
        loop_en = 1'b1;
        rx_exp.push_back(8'h30);
        tx_exp.push_back(8'h30);
        #3;
        send_rx(8'h30, 1'b1);
        wait_rx_done(2 * BIT_CLK, got);
        compare_rx("loop_rx", got);
        decode_tx(2 * BIT_CLK, d, stopb, lat);
        check("loop_latency_ok", 32'(lat <= 8), 32'd1);
        compare_tx("loop_tx", d, stopb);
        repeat (BIT_CLK) @(negedge clk);
        loop_en = 1'b0;

        // 4. Send A5, second request mid-frame is ignored
        tx0 = tx_done_cnt;
        b0  = busy_cnt;
        tx_exp.push_back(8'hA5);
        @(negedge clk);
        man_data  = 8'hA5;
        man_start = 1'b1;
        @(negedge clk);
        man_start = 1'b0;
        fork
            decode_tx(4, d, stopb, lat);
            begin
                repeat (4 * BIT_CLK) @(negedge clk);
                man_data  = 8'hFF;
                man_start = 1'b1;
                @(negedge clk);
                man_start = 1'b0;
            end
        join
        check("a5_start_seen", 32'(lat < 4), 32'd1);
        compare_tx("a5_tx", d, stopb);
        repeat (2 * BIT_CLK) @(negedge clk);
        check("a5_one_done", 32'(tx_done_cnt - tx0), 32'd1);
        check("a5_busy_cycles", 32'(busy_cnt - b0), 32'(10 * BIT_CLK));
        check("a5_idle_after", 32'({tx, tx_busy}), 32'b10);

        // 5. Glitch shorter than half a bit, then a framing error
        rx0 = rx_done_cnt;
        #3;
        rx = 1'b0;
        #(BIT_NS / 4);
        rx = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        check("glitch_no_done", 32'(rx_done_cnt - rx0), 32'd0);
        check("glitch_idle", 32'(rx_busy), 32'd0);
        send_rx(8'h55, 1'b0);
        repeat (2 * BIT_CLK) @(negedge clk);
        check("frame_err_no_done", 32'(rx_done_cnt - rx0), 32'd0);
        check("frame_err_data_held", 32'(rx_data), 32'(last_rx));
        check("frame_err_idle", 32'(rx_busy), 32'd0);

        // 6. Reset mid TX and mid RX, then a clean echoed frame
        rx0 = rx_done_cnt;
        tx0 = tx_done_cnt;
        @(negedge clk);
        man_data  = 8'h81;
        man_start = 1'b1;
        @(negedge clk);
        man_start = 1'b0;
        fork
            send_rx(8'hC3, 1'b1);
            begin
                repeat (4 * BIT_CLK) @(negedge clk);
                check("pre_rst_busy", 32'({tx_busy, rx_busy}), 32'b11);
                reset = 1'b0;
                #1;
                check("mid_rst_tx", 32'(tx), 32'd1);
                check("mid_rst_busy", 32'({tx_busy, rx_busy}), 32'b00);
                check("mid_rst_rx_data", 32'(rx_data), 32'h00);
                last_rx = 8'h00;
            end
        join
        repeat (BIT_CLK) @(negedge clk);
        reset = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        check("post_rst_no_done", 32'((rx_done_cnt - rx0) + (tx_done_cnt - tx0)), 32'd0);
        check("post_rst_idle", 32'({tx, tx_busy, rx_busy}), 32'b100);
        check("post_rst_rx_data", 32'(rx_data), 32'(last_rx));

        loop_en = 1'b1;
        rx_exp.push_back(8'hC3);
        tx_exp.push_back(8'hC3);
        #3;
        send_rx(8'hC3, 1'b1);
        wait_rx_done(2 * BIT_CLK, got);
        compare_rx("c3_rx", got);
        decode_tx(2 * BIT_CLK, d, stopb, lat);
        check("c3_latency_ok", 32'(lat <= 8), 32'd1);
        compare_tx("c3_tx", d, stopb);
        repeat (BIT_CLK) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
